// File: rtl/multibyte_add_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : seq_pkg                                                       |
// | Description: Shared types and helpers for the multi-byte add sequencer:   |
// |              FSM state encoding, operation encodings and the byte-index   |
// |              width helper.                                                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Ceiling log2, evaluated at elaboration time only.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Byte-index register width; never narrower than one bit so that
   // NBYTES=1 still gets a legal vector.
   function automatic int idx_width(input int nbytes);
      return (clog2(nbytes) > 0) ? clog2(nbytes) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multibyte_add_sequencer_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : multibyte_add_sequencer_cell                                  |
// | Description: Combinational 8-bit carry adder cell. Shared by the          |
// |              sequencer, which feeds it one operand byte per cycle.        |
// | Ports      : cin_i  - carry in                                             |
// |              a_i    - operand byte A                                       |
// |              b_i    - operand byte B                                       |
// |              sum_o  - sum byte                                             |
// |              cout_o - carry out                                            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module multibyte_add_sequencer_cell (
   input  logic       cin_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);

   logic [8:0] full_sum;

   assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
   assign sum_o    = full_sum[7:0];
   assign cout_o   = full_sum[8];

endmodule
`default_nettype wire

// File: rtl/multibyte_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : multibyte_add_sequencer                                       |
// | Description: Adds (optionally subtracts) two NBYTES*8-bit operands by     |
// |              sequencing a single 8-bit adder cell over NBYTES cycles,     |
// |              LSB byte first, with the carry chained through a register.   |
// |              Valid/ready handshakes on request and result sides.          |
// | Config     : SEQ_SUB_EN - when defined, in_op_i=1 computes A - B - cin as |
// |              A + ~B + ~cin; otherwise every request is an ADD.            |
// | Ports      : clk, rst      - clock, asynchronous active-high reset        |
// |              in_valid_i    - request valid                                 |
// |              in_ready_o    - request accepted (IDLE only)                  |
// |              in_op_i       - 0=ADD, 1=SUB                                  |
// |              in_cin_i      - carry-in / borrow-in                          |
// |              in_a_i,in_b_i - operands                                      |
// |              out_valid_o   - result valid, held until out_ready_i          |
// |              out_ready_i   - consumer accepts result                       |
// |              out_sum_o     - result                                        |
// |              out_cout_o    - carry out of MSB byte (SUB: 1 = no borrow)    |
// |              out_zero_o    - result is all zeros                           |
// |              out_ovf_o     - signed overflow                               |
// |              busy_o        - high while bytes are being processed          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module multibyte_add_sequencer
   import seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic                in_op_i,
   input  logic                in_cin_i,
   input  logic [8*NBYTES-1:0] in_a_i,
   input  logic [8*NBYTES-1:0] in_b_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [8*NBYTES-1:0] out_sum_o,
   output logic                out_cout_o,
   output logic                out_zero_o,
   output logic                out_ovf_o,
   output logic                busy_o
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = idx_width(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;        // already inverted for SUB
   logic [W-1:0]    result_q;
   logic [IW-1:0]   idx_q;
   logic            carry_q;
   logic            out_valid_q;
   logic            cout_q;
   logic            zero_q;
   logic            ovf_q;

   logic [W-1:0]    b_load;
   logic            cin_load;
   logic [7:0]      a_byte;
   logic [7:0]      b_byte;
   logic [7:0]      cell_sum;
   logic            cell_cout;
   logic [W-1:0]    result_d;

   // ------------------------------------------------------------------------
   // Operand conditioning at accept time
   // ------------------------------------------------------------------------
`ifdef SEQ_SUB_EN
   logic is_sub;
   assign is_sub   = (in_op_i == OP_SUB);
   assign b_load   = is_sub ? ~in_b_i : in_b_i;
   assign cin_load = is_sub ? ~in_cin_i : in_cin_i;
`else
   logic unused_op;
   assign unused_op = in_op_i;
   assign b_load    = in_b_i;
   assign cin_load  = in_cin_i;
`endif

   // ------------------------------------------------------------------------
   // Byte datapath through the shared cell
   // ------------------------------------------------------------------------
   assign a_byte = a_q[{idx_q, 3'b000} +: 8];
   assign b_byte = b_q[{idx_q, 3'b000} +: 8];

   multibyte_add_sequencer_cell u_cell (
      .cin_i  (carry_q),
      .a_i    (a_byte),
      .b_i    (b_byte),
      .sum_o  (cell_sum),
      .cout_o (cell_cout)
   );

   // Result with the current byte merged in; on the last byte this is the
   // complete sum, so flags can be registered from it in the same edge.
   always_comb begin
      result_d = result_q;
      result_d[{idx_q, 3'b000} +: 8] = cell_sum;
   end

   // ------------------------------------------------------------------------
   // FSM and all sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q     <= in_a_i;
                  b_q     <= b_load;
                  carry_q <= cin_load;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               result_q <= result_d;
               carry_q  <= cell_cout;
               if (idx_q == LAST_IDX) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  cout_q      <= cell_cout;
                  zero_q      <= (result_d == '0);
                  ovf_q       <= (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // in_ready is held low while reset is asserted so all outputs read 0.
   assign in_ready_o  = (state_q == IDLE) && !rst;
   assign busy_o      = (state_q == RUN);
   assign out_valid_o = out_valid_q;
   assign out_sum_o   = result_q;
   assign out_cout_o  = cout_q;
   assign out_zero_o  = zero_q;
   assign out_ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multibyte_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_multibyte_add_sequencer                                    |
// | Description: Directed self-checking bench for multibyte_add_sequencer     |
// |              with NBYTES=4. SUB vectors apply when SEQ_SUB_EN is defined; |
// |              otherwise in_op=1 is checked to behave as ADD.                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_multibyte_add_sequencer;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_op;
   logic          in_cin;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_zero;
   logic          out_ovf;
   logic          busy;

   int n_tests;
   int n_fail;

   multibyte_add_sequencer #(.NBYTES(NB)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_op_i     (in_op),
      .in_cin_i    (in_cin),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (out_sum),
      .out_cout_o  (out_cout),
      .out_zero_o  (out_zero),
      .out_ovf_o   (out_ovf),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request (inputs driven on negedge), check latency, leave the
   // result pending in DONE with out_ready low.
   task automatic issue(input logic op, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("in_ready_before_issue", in_ready, 1);
      in_op    = op;
      in_cin   = cin;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      check("busy_first_run", busy, 1);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, NB);
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] sum, input logic cout,
                               input logic zero, input logic ovf);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sum"},   out_sum,   sum);
      check({tag, "_cout"},  out_cout,  cout);
      check({tag, "_zero"},  out_zero,  zero);
      check({tag, "_ovf"},   out_ovf,   ovf);
   endtask

   // Accept the pending result and confirm the return to IDLE.
   task automatic accept;
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop_after_accept", out_valid, 0);
      check("in_ready_after_accept", in_ready, 1);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = 1'b0;
      in_cin    = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_sum", out_sum, 0);
      check("reset_flags", {out_cout, out_zero, out_ovf, busy}, 4'b0000);

      // Byte-0 carry into byte 1
      issue(1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
      check_result("add_ff_1", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      accept();

      // Full-width wrap to zero
      issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      check_result("add_wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0);
      accept();

      // Signed overflow positive -> negative
      issue(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
      check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      accept();

      // Carry-in honoured
      issue(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111);
      check_result("add_cin", 32'h2345_678A, 1'b0, 1'b0, 1'b0);
      accept();

`ifdef SEQ_SUB_EN
      issue(1'b1, 1'b0, 32'd5, 32'd7);
      check_result("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      accept();
      issue(1'b1, 1'b0, 32'd7, 32'd5);
      check_result("sub_7_5", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      accept();
`else
      // Without subtract support the op bit is ignored
      issue(1'b1, 1'b0, 32'd5, 32'd7);
      check_result("op1_as_add", 32'h0000_000C, 1'b0, 1'b0, 1'b0);
      accept();
`endif

      // Backpressure: result held 10 cycles, new requests ignored meanwhile
      issue(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000);
      in_valid = 1'b1;
      in_a     = 32'h0000_1111;
      in_b     = 32'h0000_2222;
      for (int i = 0; i < 10; i++) begin
         check("bp_sum_stable", out_sum, 32'h0000_0000);
         check("bp_flags_stable", {out_valid, out_cout, out_zero, out_ovf}, 4'b1111);
         check("bp_in_ready_low", in_ready, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      accept();

      // Reset pulse in the second RUN cycle
      @(negedge clk);
      in_op    = 1'b0;
      in_cin   = 1'b0;
      in_a     = 32'h0000_00FF;
      in_b     = 32'h0000_00FF;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_busy_run1", busy, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      repeat (6) @(negedge clk);
      check("abort_no_result", out_valid, 0);

      issue(1'b0, 1'b0, 32'd3, 32'd4);
      check_result("post_abort_add", 32'h0000_0007, 1'b0, 1'b0, 1'b0);
      accept();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
